// File: rtl/mux41_sel_arb.sv
// Round-robin arbiter driving the select input of a 4:1 word mux, with bounded
// bursts per grant and a valid/ready handshake toward the downstream consumer.
module mux41_sel_arb #(
    parameter int unsigned BURST = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       out_ready,
    output logic [3:0] gnt,
    output logic [1:0] select,
    output logic       out_valid
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] cnt_q, cnt_d;

    logic [1:0] ptr_next;
    logic [2:0] hit_idle;
    logic [2:0] hit_rel;
    logic       valid;
    logic       beat;
    logic       rel;

    // Returns {found, index} of the first requester at or after p, wrapping 3->0.
    function automatic logic [2:0] rr_search(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] idx;
        res = '0;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign ptr_next = sel_q + 2'd1;
    assign hit_idle = rr_search(req, ptr_q);
    assign hit_rel  = rr_search(req, ptr_next);
    assign valid    = (state_q == StGrant) && req[sel_q];
    assign beat     = valid && out_ready;
    // Withdrawal releases without a beat; otherwise the last beat of the burst does.
    assign rel      = (state_q == StGrant) &&
                      (!req[sel_q] || (beat && (cnt_q == 4'(BURST - 1))));

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req != 4'b0000) begin
                    state_d = StGrant;
                    sel_d   = hit_idle[1:0];
                    gnt_d   = 4'b0001 << hit_idle[1:0];
                    cnt_d   = '0;
                end
            end
            StGrant: begin
                if (rel) begin
                    ptr_d = ptr_next;
                    if (hit_rel[2]) begin
                        sel_d = hit_rel[1:0];
                        gnt_d = 4'b0001 << hit_rel[1:0];
                        cnt_d = '0;
                    end else begin
                        state_d = StIdle;
                        gnt_d   = '0;
                    end
                end else if (beat) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign select    = sel_q;
    assign out_valid = valid;

endmodule
